// File: rtl/rst_seq_pkg.sv
// Shared types, defaults and width helper for the reset sequencer slice.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        ASSERT  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int unsigned DEF_MIN_LOW = 32;
    localparam int unsigned DEF_STAGES  = 4;
    localparam int unsigned DEF_GAP     = 8;
    localparam int unsigned DEF_CNT_W   = 8;

    // Bits needed to hold values 0..n-1 (never less than 1).
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/gap_timer.sv
// Free-running counter with synchronous clear; tick pulses once every GAP cycles.
module gap_timer
    import rst_seq_pkg::*;
#(
    parameter int unsigned GAP = DEF_GAP
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned GAP_W = cnt_width(GAP);

    logic [GAP_W-1:0] gapcnt;

    assign tick = (gapcnt == GAP_W'(GAP - 1));

    always_ff @(posedge clk) begin
        if (!rst || clr || tick) begin
            gapcnt <= '0;
        end else begin
            gapcnt <= gapcnt + GAP_W'(1);
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Qualifies the incoming active-low reset pulse and releases downstream
// reset domains one at a time, reporting accepted events and runts.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned MIN_LOW = DEF_MIN_LOW,
    parameter int unsigned STAGES  = DEF_STAGES,
    parameter int unsigned GAP     = DEF_GAP,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_rst,
    output logic [STAGES-1:0] stage_rst,
    output logic              done,
    output logic              runt,
    output logic [CNT_W-1:0]  evt_cnt
);

    localparam int unsigned LOW_W = cnt_width(MIN_LOW + 1);
    localparam int unsigned IDX_W = cnt_width(STAGES);

    state_t            state, next_state;
    logic              ext_q;
    logic [LOW_W-1:0]  lowcnt, lowcnt_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [STAGES-1:0] stage_nx;
    logic [CNT_W-1:0]  evt_nx;
    logic              runt_nx;
    logic              tick;

    gap_timer #(.GAP(GAP)) u_gap_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != RELEASE),
        .tick (tick)
    );

    assign done = (state == IDLE) || (state == QUAL);

    always_comb begin
        next_state = state;
        lowcnt_nx  = lowcnt;
        idx_nx     = idx;
        stage_nx   = stage_rst;
        evt_nx     = evt_cnt;
        runt_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                stage_nx = '1;
                if (!ext_q) begin
                    next_state = QUAL;
                    lowcnt_nx  = LOW_W'(1);
                end
            end
            QUAL: begin
                // Acceptance is taken the edge after lowcnt reaches MIN_LOW,
                // so a pulse of exactly MIN_LOW samples is never a runt.
                if (lowcnt == LOW_W'(MIN_LOW)) begin
                    next_state = ASSERT;
                    stage_nx   = '0;
                    if (evt_cnt != '1) evt_nx = evt_cnt + CNT_W'(1);
                end else if (!ext_q) begin
                    lowcnt_nx = lowcnt + LOW_W'(1);
                end else begin
                    runt_nx    = 1'b1;
                    next_state = IDLE;
                end
            end
            ASSERT: begin
                stage_nx = '0;
                if (ext_q) begin
                    idx_nx      = '0;
                    stage_nx[0] = 1'b1;
                    next_state  = (STAGES == 1) ? IDLE : RELEASE;
                end
            end
            RELEASE: begin
                if (!ext_q) begin
                    stage_nx   = '0;
                    next_state = ASSERT;
                end else if (tick) begin
                    idx_nx           = idx + IDX_W'(1);
                    stage_nx[idx_nx] = 1'b1;
                    if (idx_nx == IDX_W'(STAGES - 1)) next_state = IDLE;
                end
            end
            default: next_state = ASSERT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ASSERT;
            ext_q     <= 1'b1;
            lowcnt    <= '0;
            idx       <= '0;
            stage_rst <= '0;
            evt_cnt   <= '0;
            runt      <= 1'b0;
        end else begin
            state     <= next_state;
            ext_q     <= ext_rst;
            lowcnt    <= lowcnt_nx;
            idx       <= idx_nx;
            stage_rst <= stage_nx;
            evt_cnt   <= evt_nx;
            runt      <= runt_nx;
        end
    end

endmodule
